// File: rtl/mul_add_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_add_seq                                                  |
// | Description : Sequential shift-add multiply-accumulate, result = a*b + c.  |
// |               One partial product per cycle, N cycles per operation, with  |
// |               busy/done handshake and back-to-back start from DONE.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mul_add_seq #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     c,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   result
);

  // Wide enough to hold N itself, since the counter passes N on the final step.
  localparam int                  STEP_W    = $clog2(N) + 1;
  localparam logic [STEP_W-1:0]   LAST_STEP = STEP_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                w_accept;
  logic                w_step;
  logic                w_finish;

  logic [N-1:0]        r_a;
  logic [N-1:0]        r_b;
  logic [2*N-1:0]      r_acc;
  logic [STEP_W-1:0]   r_step;
  logic [2*N-1:0]      w_addend;
  logic [2*N-1:0]      w_acc_sum;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        // start is deliberately not looked at here: requests during RUN are dropped.
        w_step = 1'b1;
        if (r_step == LAST_STEP) begin
          w_finish     = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Partial product for the current step: captured a weighted by the step index.
  always_comb begin
    w_addend  = r_b[0] ? ({{N{1'b0}}, r_a} << r_step) : '0;
    w_acc_sum = r_acc + w_addend;
  end

  // Operand capture on acceptance, then one shift-add per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_step <= '0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_acc  <= {{N{1'b0}}, c};
      r_step <= '0;
    end else if (w_step) begin
      r_acc  <= w_acc_sum;
      r_b    <= r_b >> 1;
      r_step <= r_step + STEP_W'(1);
    end
  end

  // Result only moves on the completion edge; it holds through later RUN phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else if (w_finish) begin
      result <= w_acc_sum;
    end
  end

  // busy/done are flops tracking the state register, so they equal (state==RUN)/(state==DONE).
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (w_next_state == RUN);
      done <= (w_next_state == DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_add_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mul_add_seq                                               |
// | Description : Self-checking bench for mul_add_seq (N=8): cycle model plus  |
// |               directed vectors with hand-computed results.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mul_add_seq;

  localparam int N = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [N-1:0]     a = '0;
  logic [N-1:0]     b = '0;
  logic [N-1:0]     c = '0;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   result;

  int total = 0;
  int bad   = 0;

  mul_add_seq #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .c      (c),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted operation yields a*b+c after N busy cycles.
  bit              m_valid = 1'b0;
  bit              m_busy  = 1'b0;
  bit              m_done  = 1'b0;
  logic [2*N-1:0]  m_result = '0;
  logic [2*N-1:0]  m_pending = '0;
  int              m_rem = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b1;
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_result <= '0;
      m_rem    <= 0;
    end else if (m_busy) begin
      m_done <= 1'b0;
      m_rem  <= m_rem - 1;
      if (m_rem == 1) begin
        m_busy   <= 1'b0;
        m_done   <= 1'b1;
        m_result <= m_pending;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_pending <= {{N{1'b0}}, a} * {{N{1'b0}}, b} + {{N{1'b0}}, c};
        m_rem     <= N;
        m_busy    <= 1'b1;
      end
    end
  end

  // Compare DUT outputs against the model every cycle, away from the clock edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_busy",   32'(busy),   32'(m_busy));
      check("model_done",   32'(done),   32'(m_done));
      check("model_result", 32'(result), 32'(m_result));
    end
  end

  // One operation; operands are scrambled once accepted. Returns cycles to done (0 = timeout).
  task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                        input logic [N-1:0] ic, output int lat);
    @(negedge clk);
    a = ia; b = ib; c = ic; start = 1'b1;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        a = ~ia; b = ~ib; c = ~ic;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'(N + 1));
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int lat;
    int n;
    logic [N-1:0] ra, rb, rc;
    logic [2*N-1:0] r;
    logic [N-1:0] ba [4];
    logic [N-1:0] bb [4];
    logic [N-1:0] bc [4];
    logic [2*N-1:0] bexp [4];

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy",   32'(busy),   32'd0);
    check("reset_done",   32'(done),   32'd0);
    check("reset_result", 32'(result), 32'd0);
    rst = 1'b0;

    // Basic operation: 13*11+5 = 148
    run_op(8'd13, 8'd11, 8'd5, lat);
    check("basic_result", 32'(result), 32'h0094);
    @(negedge clk);
    check("basic_held", 32'(result), 32'h0094);
    check("basic_done_low", 32'(done), 32'd0);

    // Boundary operands
    run_op(8'd255, 8'd255, 8'd255, lat);
    check("max_result", 32'(result), 32'hFF00);
    run_op(8'd0, 8'd200, 8'd7, lat);
    check("a_zero_result", 32'(result), 32'h0007);
    run_op(8'd9, 8'd0, 8'd3, lat);
    check("b_zero_result", 32'(result), 32'h0003);

    // Start re-pulsed during RUN is ignored
    @(negedge clk);
    a = 8'd13; b = 8'd11; c = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'd1; b = 8'd1; c = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int k = 0; k < 30; k++) begin
      if (done) begin
        lat = 1;
        break;
      end
      @(negedge clk);
    end
    check("repulse_done_seen", 32'(lat), 32'd1);
    check("repulse_result", 32'(result), 32'h0094);
    count_dones(15, n);
    check("repulse_single_done", 32'(n), 32'd0);

    // Back-to-back with start held high
    ba[0] = 8'd10;  bb[0] = 8'd20;  bc[0] = 8'd30;  bexp[0] = 16'd230;
    ba[1] = 8'd200; bb[1] = 8'd100; bc[1] = 8'd50;  bexp[1] = 16'd20050;
    ba[2] = 8'd1;   bb[2] = 8'd255; bc[2] = 8'd0;   bexp[2] = 16'd255;
    ba[3] = 8'd128; bb[3] = 8'd2;   bc[3] = 8'd1;   bexp[3] = 16'd257;
    @(negedge clk);
    a = ba[0]; b = bb[0]; c = bc[0]; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lat = 0;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (done) begin
          lat = k;
          break;
        end
      end
      check("b2b_interval", 32'(lat), 32'(N + 1));
      check("b2b_result", 32'(result), 32'(bexp[i]));
      if (i < 3) begin
        a = ba[i+1]; b = bb[i+1]; c = bc[i+1];
      end else begin
        start = 1'b0;
      end
    end

    // Reset in cycle 4 of RUN aborts the operation
    @(negedge clk);
    a = 8'd50; b = 8'd3; c = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_result", 32'(result), 32'd0);
    count_dones(15, n);
    check("abort_no_done", 32'(n), 32'd0);
    run_op(8'd6, 8'd7, 8'd8, lat);
    check("after_abort_result", 32'(result), 32'd50);

    // Random division-check vectors: c < b, b != 0
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      rc = 8'($urandom_range(0, int'(rb) - 1));
      run_op(ra, rb, rc, lat);
      r = result;
      check("rand_quotient",  32'(r / {{N{1'b0}}, rb}), 32'(ra));
      check("rand_remainder", 32'(r % {{N{1'b0}}, rb}), 32'(rc));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
